// File: rtl/wb_regfile.sv
// MIPS write-back latch and 32-entry register file with two bypassed read ports.
// The WB latch commits to the array on the edge after capture; reads see EX and WB results early.
module wb_regfile #(
    parameter int REG_LENGTH   = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int REG_NUM      = 32,
    parameter int CNT_LEN      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_LENGTH-1:0]   regcData_i,
    input  logic [REG_ADDR_LEN-1:0] regcAddr_i,
    input  logic                    regcWr_i,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    rdEnA,
    input  logic [REG_ADDR_LEN-1:0] rdAddrA,
    output logic [REG_LENGTH-1:0]   rdDataA,
    input  logic                    rdEnB,
    input  logic [REG_ADDR_LEN-1:0] rdAddrB,
    output logic [REG_LENGTH-1:0]   rdDataB,
    output logic                    wbWr,
    output logic [REG_ADDR_LEN-1:0] wbAddr,
    output logic [REG_LENGTH-1:0]   wbData,
    output logic [CNT_LEN-1:0]      commitCnt
);
    localparam int NUM_PORTS = 2;

    logic [REG_NUM-1:0][REG_LENGTH-1:0]     regs;
    logic [NUM_PORTS-1:0]                   rd_en;
    logic [NUM_PORTS-1:0][REG_ADDR_LEN-1:0] rd_addr;
    logic [NUM_PORTS-1:0][REG_LENGTH-1:0]   rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs      <= '0;
            wbWr      <= 1'b0;
            wbAddr    <= '0;
            wbData    <= '0;
            commitCnt <= '0;
        end else begin
            if (!stall) begin
                if (wbWr && wbAddr != '0) begin
                    regs[wbAddr] <= wbData;
                    commitCnt    <= commitCnt + CNT_LEN'(1);
                end
                wbAddr <= regcAddr_i;
                wbData <= regcData_i;
            end
            // Flush kills the latch valid even while stalled; the held data is simply dropped.
            if (flush)
                wbWr <= 1'b0;
            else if (!stall)
                wbWr <= regcWr_i && (regcAddr_i != '0);
        end
    end

    assign rd_en   = {rdEnB, rdEnA};
    assign rd_addr = {rdAddrB, rdAddrA};
    assign rdDataA = rd_data[0];
    assign rdDataB = rd_data[1];

    // Newest value wins: live EX result, then WB latch, then the array.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            if (!rd_en[p] || rd_addr[p] == '0)
                rd_data[p] = '0;
            else if (regcWr_i && regcAddr_i == rd_addr[p] && !stall)
                rd_data[p] = regcData_i;
            else if (wbWr && wbAddr == rd_addr[p])
                rd_data[p] = wbData;
            else
                rd_data[p] = regs[rd_addr[p]];
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: inputs driven on negedge, outputs sampled 1ns later.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] regcData_i;
    logic [4:0]  regcAddr_i;
    logic        regcWr_i, stall, flush;
    logic        rdEnA, rdEnB;
    logic [4:0]  rdAddrA, rdAddrB;
    logic [31:0] rdDataA, rdDataB;
    logic        wbWr;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic [31:0] commitCnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
        .stall(stall), .flush(flush),
        .rdEnA(rdEnA), .rdAddrA(rdAddrA), .rdDataA(rdDataA),
        .rdEnB(rdEnB), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .wbWr(wbWr), .wbAddr(wbAddr), .wbData(wbData), .commitCnt(commitCnt)
    );

    typedef struct {
        logic        rst;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wr, stall, flush;
        logic        en_a;
        logic [4:0]  a_a;
        logic        en_b;
        logic [4:0]  a_b;
        logic [31:0] exp_a, exp_b;
        logic        exp_wr;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic [31:0] d, logic [4:0] ad, logic w, logic s, logic f,
                                logic ea, logic [4:0] aa, logic eb, logic [4:0] ab,
                                logic [31:0] xa, logic [31:0] xb, logic xw, logic [31:0] xc);
        vec_t v;
        v.rst = r; v.data = d; v.addr = ad; v.wr = w; v.stall = s; v.flush = f;
        v.en_a = ea; v.a_a = aa; v.en_b = eb; v.a_b = ab;
        v.exp_a = xa; v.exp_b = xb; v.exp_wr = xw; v.exp_cnt = xc;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // Expected read values are the pre-edge combinational result; wbWr/commitCnt reflect prior edges.
        //                rst data          ad wr st fl  enA aA enB aB  expA          expB          wr cnt
        vecs[0]  = mk(0, 32'h1234ABCD, 5, 1, 0, 0,  1, 5, 1, 5,  32'h1234ABCD, 32'h1234ABCD, 0, 0);
        vecs[1]  = mk(0, 32'h0,        0, 0, 0, 0,  1, 5, 1, 6,  32'h1234ABCD, 32'h0,        1, 0);
        vecs[2]  = mk(0, 32'h0,        0, 0, 0, 0,  1, 5, 0, 5,  32'h1234ABCD, 32'h0,        0, 1);
        vecs[3]  = mk(0, 32'hFFFFFFFF, 0, 1, 0, 0,  1, 0, 0, 5,  32'h0,        32'h0,        0, 1);
        vecs[4]  = mk(0, 32'h0,        0, 0, 0, 0,  1, 0, 1, 5,  32'h0,        32'h1234ABCD, 0, 1);
        vecs[5]  = mk(0, 32'h11,       7, 1, 0, 0,  1, 7, 1, 7,  32'h11,       32'h11,       0, 1);
        vecs[6]  = mk(0, 32'h22,       7, 1, 0, 0,  1, 7, 1, 7,  32'h22,       32'h22,       1, 1);
        vecs[7]  = mk(0, 32'h0,        0, 0, 0, 0,  1, 7, 1, 7,  32'h22,       32'h22,       1, 2);
        vecs[8]  = mk(0, 32'h0,        0, 0, 0, 0,  1, 7, 1, 5,  32'h22,       32'h1234ABCD, 0, 3);
        vecs[9]  = mk(0, 32'h55,       3, 1, 0, 0,  1, 3, 1, 3,  32'h55,       32'h55,       0, 3);
        vecs[10] = mk(0, 32'hAA,       3, 1, 0, 0,  1, 3, 1, 3,  32'hAA,       32'hAA,       1, 3);
        vecs[11] = mk(0, 32'hBB,       3, 1, 1, 0,  1, 3, 1, 9,  32'hAA,       32'h0,        1, 4);
        vecs[12] = mk(0, 32'hBB,       3, 1, 1, 0,  1, 3, 0, 3,  32'hAA,       32'h0,        1, 4);
        vecs[13] = mk(0, 32'hBB,       3, 1, 1, 0,  1, 3, 1, 3,  32'hAA,       32'hAA,       1, 4);
        vecs[14] = mk(0, 32'hCC,       4, 1, 0, 1,  1, 3, 1, 4,  32'hAA,       32'hCC,       1, 4);
        vecs[15] = mk(0, 32'h0,        0, 0, 0, 0,  1, 3, 1, 4,  32'hAA,       32'h0,        0, 5);
        vecs[16] = mk(0, 32'h0,        0, 0, 0, 0,  1, 3, 1, 4,  32'hAA,       32'h0,        0, 5);
        vecs[17] = mk(0, 32'h77,       8, 1, 0, 0,  1, 8, 1, 8,  32'h77,       32'h77,       0, 5);
        vecs[18] = mk(0, 32'h0,        0, 0, 1, 1,  1, 8, 1, 8,  32'h77,       32'h77,       1, 5);
        vecs[19] = mk(0, 32'h0,        0, 0, 0, 0,  1, 8, 1, 3,  32'h0,        32'hAA,       0, 5);
        vecs[20] = mk(0, 32'h99,       9, 1, 0, 0,  1, 9, 1, 9,  32'h99,       32'h99,       0, 5);
        vecs[21] = mk(1, 32'h0,        0, 0, 1, 1,  1, 9, 1, 3,  32'h99,       32'hAA,       1, 5);
        vecs[22] = mk(0, 32'h0,        0, 0, 0, 0,  1, 9, 1, 3,  32'h0,        32'h0,        0, 0);
        vecs[23] = mk(0, 32'h0,        0, 0, 0, 0,  1, 5, 1, 7,  32'h0,        32'h0,        0, 0);

        rst = 1'b1; regcData_i = '0; regcAddr_i = '0; regcWr_i = 1'b0;
        stall = 1'b0; flush = 1'b0;
        rdEnA = 1'b1; rdAddrA = 5'd5; rdEnB = 1'b1; rdAddrB = 5'd31;

        // Power-on reset: one edge clears everything.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset rdDataA", rdDataA, 32'h0);
        check("reset rdDataB", rdDataB, 32'h0);
        check("reset wbWr", {31'b0, wbWr}, 32'h0);
        check("reset wbAddr", {27'b0, wbAddr}, 32'h0);
        check("reset wbData", wbData, 32'h0);
        check("reset commitCnt", commitCnt, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            regcData_i = vecs[i].data;
            regcAddr_i = vecs[i].addr;
            regcWr_i   = vecs[i].wr;
            stall      = vecs[i].stall;
            flush      = vecs[i].flush;
            rdEnA      = vecs[i].en_a;
            rdAddrA    = vecs[i].a_a;
            rdEnB      = vecs[i].en_b;
            rdAddrB    = vecs[i].a_b;
            #1;
            check($sformatf("v%0d rdDataA", i), rdDataA, vecs[i].exp_a);
            check($sformatf("v%0d rdDataB", i), rdDataB, vecs[i].exp_b);
            check($sformatf("v%0d wbWr", i), {31'b0, wbWr}, {31'b0, vecs[i].exp_wr});
            check($sformatf("v%0d commitCnt", i), commitCnt, vecs[i].exp_cnt);
        end

        // Latch contents after a plain capture, and held across a stall.
        @(negedge clk);
        regcData_i = 32'hDEADBEEF; regcAddr_i = 5'd12; regcWr_i = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        regcData_i = 32'h0BAD0BAD; regcAddr_i = 5'd13; stall = 1'b1;
        #1;
        check("capture wbAddr", {27'b0, wbAddr}, 32'd12);
        check("capture wbData", wbData, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("stall wbAddr", {27'b0, wbAddr}, 32'd12);
        check("stall wbData", wbData, 32'hDEADBEEF);
        check("stall commitCnt", commitCnt, 32'h0);
        regcWr_i = 1'b0; stall = 1'b0;
        @(negedge clk);
        #1;
        check("release commitCnt", commitCnt, 32'h1);
        rdAddrA = 5'd12;
        #1;
        check("release array read", rdDataA, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the MIPS_CPU pipeline. It captures the execute-stage result triple (data, address, write enable) into a WB pipeline latch and commits it to a 32-entry register array one cycle later. It serves two combinational read ports to the decode stage, with bypass from both the incoming EX result and the WB latch. It also maintains a commit counter for bring-up and verification.

## Interface
- REG_LENGTH, 32, data width of every register
- REG_ADDR_LEN, 5, register address width
- REG_NUM, 32, number of registers; must equal 2**REG_ADDR_LEN
- CNT_LEN, 32, width of commit counter
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- regcData_i  input  REG_LENGTH  EX result data
- regcAddr_i  input  REG_ADDR_LEN  EX destination address
- regcWr_i  input  1  EX destination write enable
- stall  input  1  hold WB latch; EX inputs ignored this cycle
- flush  input  1  invalidate WB latch
- rdEnA / rdEnB  input  1  read enable, port A / B
- rdAddrA / rdAddrB  input  REG_ADDR_LEN  read address, port A / B
- rdDataA / rdDataB  output  REG_LENGTH  read data, port A / B (combinational)
- wbWr  output  1  WB latch write valid (registered)
- wbAddr  output  REG_ADDR_LEN  WB latch address (registered)
- wbData  output  REG_LENGTH  WB latch data (registered)
- commitCnt  output  CNT_LEN  number of committed register writes

## Operation
- WB latch: {wbWr, wbAddr, wbData}. Each non-stalled edge loads {regcWr_i && regcAddr_i!=0, regcAddr_i, regcData_i}. Any write to address 0 loads wbWr=0.
- Commit: on each non-stalled edge with wbWr=1, write reg[wbAddr] <= wbData and increment commitCnt. The commit and the latch load happen on the same edge.
- Stall=1: latch holds, no commit, commitCnt holds. Upstream holds the EX outputs.
- Flush=1: on the edge, wbWr <= 0. wbAddr and wbData load as normal; the latched entry still commits if wbWr was 1 and stall=0. Flush has priority over stall for wbWr.
- Register 0 reads as 0 always and is never written.
- Read port X, evaluated in priority order:
  - rdEnX=0 -> 0
  - rdAddrX=0 -> 0
  - regcWr_i=1 && regcAddr_i==rdAddrX && stall=0 -> regcData_i
  - wbWr=1 && wbAddr==rdAddrX -> wbData
  - otherwise reg[rdAddrX]
- Both ports are independent; same address on both ports returns identical data.
- commitCnt wraps from all-ones to 0 without a flag.

## Timing
- Reset (rst=1 at edge): all REG_NUM registers <= 0, wbWr <= 0, wbAddr <= 0, wbData <= 0, commitCnt <= 0. This overrides stall, flush and any pending commit; the in-flight latch entry is discarded.
- Reset is synchronous only: outputs change on the edge, not asynchronously.
- rdDataA/B during reset are combinational from cleared state; after the reset edge all reads return 0.
- Latency: EX result at cycle N is visible on wbData after edge N and in the array after edge N+1. Read bypass makes it visible to readers in cycle N itself, with zero cycles of read-after-write delay.
- Back-to-back writes to the same address: the EX bypass (newest) wins over wbData, which wins over the array.
- Stall held k cycles: the latch is frozen k cycles and the commit occurs on the first non-stalled edge.

## Test plan
- Reset: preload several registers, assert rst one cycle -> all reads 0, wbWr=0, commitCnt=0 next cycle.
- Basic write/read: EX {data=0x1234ABCD, addr=5, wr=1} at cycle 0 -> rdDataA(5)=0x1234ABCD in cycle 0 via bypass, cycle 1 via wbData, cycle 2 onward via array; commitCnt=1 after edge 1.
- $0 protection: EX {data=0xFFFFFFFF, addr=0, wr=1} -> wbWr=0, reads of 0 return 0, commitCnt unchanged.
- Bypass priority: addr 7 written with 0x11 at cycle 0 then 0x22 at cycle 1 -> port B reads 0x22 in cycle 1, array holds 0x22 after edge 2; both ports agree.
- Stall/flush: latch holds {addr=3, 0xAA}; stall for 3 cycles -> no commit, reg3 stays old; then flush with stall=0 -> reg3=0xAA committed, wbWr=0 afterwards.
- Mid-operation reset: a pending write is in the WB latch when rst is asserted -> the write is never committed; reg[addr]=0 and commitCnt=0.
